// File: rtl/textcon_writer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | textcon_writer_pkg: console geometry, control codes, byte classifier. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package textcon_writer_pkg;

    localparam int VMEMSTART = 1024;
    localparam int COLS      = 80;
    localparam int ROWS      = 60;
    localparam int CELLS     = COLS * ROWS;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_SP = 8'h20;

    // Bit 7 carries the blink-inverse attribute, so both halves are printable.
    function automatic logic is_printable(input logic [7:0] b);
        return ((b >= 8'h20) && (b <= 8'h7E)) || ((b >= 8'hA0) && (b <= 8'hFE));
    endfunction

endpackage : textcon_writer_pkg
`default_nettype wire

// File: rtl/textcon_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | textcon_writer: ASCII stream to 80x60 console vmem, with scroll/clear. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module textcon_writer
    import textcon_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [12:0] vmem_addr,
    output logic [7:0]  vmem_wdata,
    output logic        vmem_we,
    input  logic [7:0]  vmem_rdata,
    output logic [6:0]  cur_col,
    output logic [5:0]  cur_row,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUT     = 3'd1;
    localparam logic [2:0] S_LF      = 3'd2;
    localparam logic [2:0] S_SCRL_RD = 3'd3;
    localparam logic [2:0] S_SCRL_WR = 3'd4;
    localparam logic [2:0] S_CLR     = 3'd5;

    localparam logic [12:0] C_BASE     = 13'(VMEMSTART);
    localparam logic [12:0] C_LAST     = 13'(VMEMSTART + CELLS - 1);
    localparam logic [12:0] C_SCRL_SRC = 13'(VMEMSTART + COLS);
    localparam logic [12:0] C_LAST_ROW = 13'(VMEMSTART + COLS * (ROWS - 1));
    localparam logic [12:0] C_COLS     = 13'(COLS);
    localparam logic [6:0]  C_MAX_COL  = 7'(COLS - 1);
    localparam logic [5:0]  C_MAX_ROW  = 6'(ROWS - 1);

    logic [2:0]  r_state;
    logic [6:0]  r_col;
    logic [5:0]  r_row;
    logic [12:0] r_rowbase;
    logic [12:0] r_clr_ptr;
    logic [12:0] r_clr_end;
    logic [12:0] r_src;
    logic [7:0]  r_char;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLR;
            r_col     <= '0;
            r_row     <= '0;
            r_rowbase <= C_BASE;
            r_clr_ptr <= C_BASE;
            r_clr_end <= C_LAST;
            r_src     <= C_SCRL_SRC;
            r_char    <= CH_SP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_printable(in_data)) begin
                            r_char  <= in_data;
                            r_state <= S_PUT;
                        end else begin
                            case (in_data)
                                CH_CR: r_col <= '0;
                                CH_BS: if (r_col != '0) r_col <= r_col - 7'd1;
                                CH_LF: r_state <= S_LF;
                                CH_FF: begin
                                    r_col     <= '0;
                                    r_row     <= '0;
                                    r_rowbase <= C_BASE;
                                    r_clr_ptr <= C_BASE;
                                    r_clr_end <= C_LAST;
                                    r_state   <= S_CLR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_PUT: begin
                    if (r_col < C_MAX_COL) begin
                        r_col   <= r_col + 7'd1;
                        r_state <= S_IDLE;
                    end else begin
                        r_col   <= '0;
                        r_state <= S_LF;
                    end
                end
                S_LF: begin
                    if (r_row < C_MAX_ROW) begin
                        r_row     <= r_row + 6'd1;
                        r_rowbase <= r_rowbase + C_COLS;
                        r_state   <= S_IDLE;
                    end else begin
                        r_src   <= C_SCRL_SRC;
                        r_state <= S_SCRL_RD;
                    end
                end
                S_SCRL_RD: r_state <= S_SCRL_WR;
                S_SCRL_WR: begin
                    r_src <= r_src + 13'd1;
                    if (r_src == C_LAST) begin
                        r_clr_ptr <= C_LAST_ROW;
                        r_clr_end <= C_LAST;
                        r_state   <= S_CLR;
                    end else begin
                        r_state <= S_SCRL_RD;
                    end
                end
                S_CLR: begin
                    if (r_clr_ptr == r_clr_end) r_state <= S_IDLE;
                    else                        r_clr_ptr <= r_clr_ptr + 13'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Port decode depends only on registered state; rst forces the idle-bus values.
    always_comb begin
        vmem_addr  = C_BASE;
        vmem_wdata = CH_SP;
        vmem_we    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_PUT: begin
                    vmem_addr  = r_rowbase + {6'd0, r_col};
                    vmem_wdata = r_char;
                    vmem_we    = 1'b1;
                end
                S_SCRL_RD: vmem_addr = r_src;
                S_SCRL_WR: begin
                    vmem_addr  = r_src - C_COLS;
                    vmem_wdata = vmem_rdata;
                    vmem_we    = 1'b1;
                end
                S_CLR: begin
                    vmem_addr = r_clr_ptr;
                    vmem_we   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = !rst && (r_state == S_IDLE);
    assign busy     = rst || (r_state != S_IDLE);
    assign cur_col  = r_col;
    assign cur_row  = r_row;

endmodule : textcon_writer
`default_nettype wire

// File: tb/tb_textcon_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_textcon_writer: random/directed byte streams vs. a screen model.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_textcon_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] vmem_addr;
    logic [7:0]  vmem_wdata;
    logic        vmem_we;
    logic [7:0]  vmem_rdata;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;
    logic        busy;

    textcon_writer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .vmem_addr  (vmem_addr),
        .vmem_wdata (vmem_wdata),
        .vmem_we    (vmem_we),
        .vmem_rdata (vmem_rdata),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Registered-read BRAM port plus a log of every write.
    logic [7:0] mem [0:8191];
    int         log_addr [0:65535];
    int         wr_total = 0;

    always @(posedge clk) begin
        vmem_rdata <= mem[vmem_addr];
        if (vmem_we) begin
            mem[vmem_addr]               <= vmem_wdata;
            log_addr[wr_total & 16'hFFFF] <= int'(vmem_addr);
            wr_total                     <= wr_total + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Screen model: rows of 80 cells starting at 1024.
    logic [7:0] exp_mem [0:8191];
    int er = 0;
    int ec = 0;

    function automatic bit tb_printable(input int b);
        return (b >= 32 && b <= 126) || (b >= 160 && b <= 254);
    endfunction

    task automatic model_clear();
        for (int a = 1024; a < 1024 + 4800; a++) exp_mem[a] = 8'h20;
        er = 0;
        ec = 0;
    endtask

    task automatic model_nl(inout int lat);
        if (er < 59) begin
            er++;
        end else begin
            for (int a = 1024; a < 1024 + 59 * 80; a++) exp_mem[a] = exp_mem[a + 80];
            for (int a = 1024 + 59 * 80; a < 1024 + 4800; a++) exp_mem[a] = 8'h20;
            lat += 9520;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output int lat);
        lat = 1;
        if (tb_printable(int'(b))) begin
            exp_mem[1024 + er * 80 + ec] = b;
            lat = 2;
            if (ec == 79) begin
                ec = 0;
                lat += 1;
                model_nl(lat);
            end else begin
                ec++;
            end
        end else if (b == 8'h0D) begin
            ec = 0;
        end else if (b == 8'h08) begin
            if (ec > 0) ec--;
        end else if (b == 8'h0A) begin
            lat = 2;
            model_nl(lat);
        end else if (b == 8'h0C) begin
            model_clear();
            lat = 4801;
        end
    endtask

    task automatic cmp_mem(input string tag);
        int nmis = 0;
        int first = -1;
        for (int a = 1024; a < 1024 + 4800; a++) begin
            if (mem[a] !== exp_mem[a]) begin
                nmis++;
                if (first < 0) first = a;
            end
        end
        if (nmis != 0)
            $display("note %s: first differing cell %0d holds 0x%0h, model 0x%0h",
                     tag, first, mem[first], exp_mem[first]);
        check(tag, nmis, 0);
    endtask

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (!in_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        int lat;
        int exp_lat;
        wait_ready(30000, n);
        check("ready_before_send", int'(in_ready), 1);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!in_ready && lat < 30000) begin
            @(negedge clk);
            lat++;
        end
        model_byte(b, exp_lat);
        check("latency", lat, exp_lat);
        check("cur_col", int'(cur_col), ec);
        check("cur_row", int'(cur_row), er);
    endtask

    task automatic reset_phase(input string tag);
        int base;
        int n;
        #1;
        check({tag, "_rst_we"},    int'(vmem_we), 0);
        check({tag, "_rst_addr"},  int'(vmem_addr), 1024);
        check({tag, "_rst_wdata"}, int'(vmem_wdata), 32);
        check({tag, "_rst_ready"}, int'(in_ready), 0);
        check({tag, "_rst_busy"},  int'(busy), 1);
        @(negedge clk);
        rst  = 1'b0;
        base = wr_total;
        model_clear();
        wait_ready(6000, n);
        check({tag, "_ready"},      int'(in_ready), 1);
        check({tag, "_clr_writes"}, wr_total - base, 4800);
        check({tag, "_clr_first"},  log_addr[base & 16'hFFFF], 1024);
        check({tag, "_clr_last"},   log_addr[(base + 4799) & 16'hFFFF], 5823);
        check({tag, "_col"},        int'(cur_col), 0);
        check({tag, "_row"},        int'(cur_row), 0);
        cmp_mem({tag, "_clear"});
    endtask

    initial begin
        logic [7:0] b;
        int n;
        int r;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_phase("reset");

        send(8'h41);
        send(8'h42);
        cmp_mem("ab");

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(160, 254));
                else                           b = 8'($urandom_range(32, 126));
            end else if (r < 70) b = 8'h0A;
            else if (r < 78) b = 8'h0D;
            else if (r < 86) b = 8'h08;
            else begin
                case ($urandom_range(0, 6))
                    0: b = 8'h00;
                    1: b = 8'h01;
                    2: b = 8'h7F;
                    3: b = 8'h80;
                    4: b = 8'h9F;
                    5: b = 8'hFF;
                    default: b = 8'h1B;
                endcase
            end
            send(b);
        end
        cmp_mem("random");

        send(8'h0C);
        cmp_mem("ff_clear");
        send(8'hC1);
        check("attr_bit7", int'(mem[1024]), 8'hC1);
        send(8'h01);
        send(8'h7F);
        cmp_mem("ignored");

        send(8'h0C);
        for (int i = 0; i < 80; i++) send(8'h78);
        send(8'h0D);
        send(8'h08);
        cmp_mem("autowrap");

        send(8'h0C);
        for (int row = 0; row < 59; row++)
            for (int i = 0; i < 80; i++) send(8'(row + 8'h30));
        for (int i = 0; i < 79; i++) send(8'h6B);
        send(8'h0D);
        for (int i = 0; i < 5; i++) send(8'h6B);
        cmp_mem("prefill");
        send(8'h0A);
        cmp_mem("lf_scroll");

        send(8'h0D);
        for (int i = 0; i < 80; i++) send(8'h77);
        cmp_mem("wrap_scroll");

        wait_ready(30000, n);
        in_data  = 8'h0A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_scroll_busy", int'(busy), 1);
        rst = 1'b1;
        reset_phase("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_textcon_writer
`default_nettype wire

// File: doc/textcon_writer.md
# textcon_writer

Character-stream writer for the 80x60 monochrome text console: accepts ASCII bytes on a valid/ready stream and updates the console's vmem text area (cursor advance, CR/LF/BS, form-feed clear, hardware scroll). It sits on the CPU side of the vmem dual-port BRAM, on the opposite port from the VGA scan-out block. The scan-out block reads the cell codes that this block writes.

## Interface
- VMEMSTART, 1024: vmem address of cell (row 0, col 0).
- COLS, 80: characters per row.
- ROWS, 60: rows per screen.
- clk  in  1  system clock (100 MHz). The only clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  8  character byte. Bit 7 = blink-inverse attribute.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- vmem_addr  out  13  vmem address.
- vmem_wdata  out  8  vmem write data.
- vmem_we  out  1  vmem write enable.
- vmem_rdata  in  8  vmem read data. Valid one cycle after vmem_addr is presented.
- cur_col  out  7  cursor column, 0..COLS-1.
- cur_row  out  6  cursor row, 0..ROWS-1.
- busy  out  1  high in any state other than S_IDLE.

## Operation
- Transfer occurs when in_valid & in_ready. in_ready = (state == S_IDLE).
- Byte decode:
  - 0x20–0x7E and 0xA0–0xFE are printable and are written verbatim, bit 7 included.
  - 0x0A = LF, 0x0D = CR, 0x08 = BS, 0x0C = FF.
  - Every other byte is consumed with no effect.
- The block keeps a row base pointer rowbase = VMEMSTART + cur_row*COLS, updated by ±COLS. No multiplier.
- States:
  - S_CLR: write 0x20 to cells clr_ptr..clr_end, one per cycle. Then go to S_IDLE.
  - S_IDLE: accept a byte.
    - Printable → S_PUT.
    - CR: cur_col=0. Stay in S_IDLE.
    - BS: if cur_col>0, cur_col-1. The cell is not erased.
    - LF → S_LF.
    - FF: cursor=(0,0), clr_ptr=VMEMSTART, clr_end=VMEMSTART+COLS*ROWS-1 → S_CLR.
  - S_PUT: vmem_addr=rowbase+cur_col, wdata=byte, we=1.
    - If cur_col<COLS-1: cur_col+1, then S_IDLE.
    - Else: cur_col=0, then S_LF (autowrap).
  - S_LF:
    - If cur_row<ROWS-1: cur_row+1, rowbase+COLS, then S_IDLE.
    - Else: src=VMEMSTART+COLS, then S_SCRL_RD.
  - S_SCRL_RD: vmem_addr=src, we=0. Next state S_SCRL_WR.
  - S_SCRL_WR: vmem_addr=src-COLS, wdata=vmem_rdata, we=1, src+1.
    - If src was VMEMSTART+COLS*ROWS-1: clr_ptr=VMEMSTART+COLS*(ROWS-1), clr_end=last cell, then S_CLR.
    - Else: S_SCRL_RD.
- CR and LF are independent. LF does not reset the column.
- vmem_addr, vmem_wdata and vmem_we are combinational decodes of registered state only, plus the vmem_rdata passthrough in S_SCRL_WR. There is no path from in_* to any output.

## Timing
- Reset:
  - State = S_CLR over the full screen. Cursor = (0,0), rowbase = VMEMSTART.
  - During the rst cycle itself: vmem_we=0, vmem_addr=VMEMSTART, vmem_wdata=0x20, in_ready=0, busy=1.
  - The first clear write happens in the cycle after rst is released. in_ready rises after COLS*ROWS = 4800 write cycles.
- rst asserted mid-operation (scroll or clear) aborts it and restarts the full-screen clear. A partial scroll is never resumed.
- Printable byte accepted at cycle T:
  - Write occurs at T+1.
  - in_ready is high again at T+2.
  - cur_col is updated and visible at T+2.
- CR, BS, ignored byte: one cycle. in_ready stays high and back-to-back transfers are allowed.
- LF without scroll: accept at T, in S_LF at T+1, cur_row updated at T+2.
- LF with scroll (cur_row=59): 1 cycle S_LF, then 2×4720 = 9440 copy cycles, then 80 clear cycles. Cursor ends at (59, unchanged col). A wrap-triggered scroll ends at (59, 0).
- FF: 4800 clear cycles, busy throughout.
- in_valid held while busy is simply stalled. in_data must remain stable until the transfer.

## Structure
- The shared include holds VMEMSTART, COLS, ROWS and the control codes CH_LF, CH_CR, CH_BS, CH_FF, CH_SP. The VGA scan-out uses the same geometry values.
- State encoding is a localparam inside this block: S_IDLE, S_PUT, S_LF, S_SCRL_RD, S_SCRL_WR, S_CLR.
- Single module. No sub-module: the cursor/rowbase logic is too small to split out.

## Test plan
- Reset → exactly 4800 writes of 0x20 to 1024..5823. in_ready rises on the next cycle. cur=(0,0).
- Send "AB" → vmem[1024]=0x41, vmem[1025]=0x42. cur_col=2. Each byte is accepted 2 cycles apart.
- 80 × 'x' from (0,0) → vmem[1024..1103]='x', cursor (1,0) via autowrap. Then CR, BS at col 0 → cursor stays (1,0).
- Prefill row r with byte r+0x30, cursor at (59,5), send LF → row r holds r+0x31 for r=0..58, row 59 is all 0x20, cursor (59,5). busy lasts 1+9440+80 cycles.
- Send 0xC1 then 0x0C → 0xC1 is written with bit 7 intact. FF then clears all 4800 cells and sets cursor (0,0). Bytes 0x01 and 0x7F leave vmem unchanged.
- Assert rst for one cycle mid-scroll → the full 4800-cell clear restarts from 1024 and the cursor is (0,0).
